ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the max cycles mem_start is held without mem_done before abort (1..255).
REQ-002 SHALL have ports `clock  in  1  system clock, rising edge` and `reset_n  in  1  reset`; reset reset_n, asynchronous, active-low; clock clock.
REQ-003 SHALL have `fetch_start  in  1  instruction-fetch read request, level, held until fetch_done`.
REQ-004 SHALL have `fetch_address  in  16`, `fetch_bytes  in  16`: fetch request address and size.
REQ-005 SHALL have `fetch_q  out  256  fetch read data` and `fetch_done  out  1  one-cycle completion pulse`.
REQ-006 SHALL have `stk_rd_start  in  1`, `stk_rd_address  in  16`, `stk_rd_bytes  in  16`, `stk_rd_q  out  256` and `stk_rd_done  out  1`: stack read port, same protocol as fetch.
REQ-007 SHALL have `stk_wr_start  in  1`, `stk_wr_address  in  16`, `stk_wr_bytes  in  16`, `stk_wr_data  in  256` and `stk_wr_done  out  1`: stack write port.
REQ-008 SHALL have `mem_start  out  1`, `mem_we  out  1`, `mem_address  out  16`, `mem_bytes  out  16` and `mem_wdata  out  256`: backend request, all registered.
REQ-009 SHALL have `mem_q  in  256` and `mem_done  in  1`: backend response; mem_done stays high while mem_start is high after completion.
REQ-010 SHALL have `grant  out  2  owner: 00 none, 01 fetch, 10 stk_rd, 11 stk_wr`.
REQ-011 SHALL have `busy  out  1  state != IDLE` and `timeout_err  out  1  one-cycle pulse on abort`.

Function
REQ-012 SHALL implement a state machine with states IDLE, ISSUE, RELEASE.
REQ-013 In IDLE, a requester is eligible when its start is high and its served flag is clear.
REQ-014 In IDLE, the arbiter SHALL pick one eligible requester round-robin, searching in order fetch→stk_rd→stk_wr starting after last_grant; last_grant resets to stk_wr, so fetch wins first.
REQ-015 On a pick, the arbiter SHALL latch the winner's address, bytes and (for stk_wr only) data into the mem_* registers, set mem_we=1 for stk_wr else 0, set mem_start=1 and grant, update last_grant, and enter ISSUE; mem_start goes high on the cycle after the request is sampled.
REQ-016 The mem_* outputs and grant SHALL stay constant throughout ISSUE.
REQ-017 In ISSUE, when mem_done is sampled high: capture mem_q into the owner's q register (read ports only), pulse the owner's done exactly one cycle (next cycle), clear mem_start, set the owner's served flag if its start is still high, and enter RELEASE.
REQ-018 The q registers SHALL hold their value until the next completion for the same port.
REQ-019 In ISSUE, an 8-bit cycle counter SHALL count cycles with mem_done low; when it reaches TIMEOUT, the arbiter SHALL clear mem_start, pulse timeout_err and the owner's done together, leave the owner's q unchanged, and enter RELEASE.
REQ-020 In RELEASE, the arbiter SHALL wait until mem_done is sampled low, then clear grant and enter IDLE; a new pick can occur no earlier than the cycle after entering IDLE.
REQ-021 Minimum latency with a 1-cycle backend SHALL be: start sampled cycle 0 → mem_start cycle 1 → mem_done cycle 2 → done pulse cycle 3.
REQ-022 A served flag SHALL clear on any cycle its start is sampled low, preventing double-issue of a held request.
REQ-023 If a requester drops start mid-transaction, the backend transaction SHALL still complete and done still pulse; no served flag is set.
REQ-024 Simultaneous requests SHALL be serialized; at most one done pulses per cycle, and grant never changes outside IDLE/RELEASE transitions.

Reset
REQ-025 On reset_n low (async), the arbiter SHALL go to IDLE and clear all of mem_start, mem_we, mem_address, mem_bytes, mem_wdata, all q registers, all done, timeout_err, busy, grant, served flags and the counter, and set last_grant=stk_wr.
REQ-026 Reset mid-ISSUE SHALL drop mem_start immediately with no done pulse; after release, the first transaction SHALL behave as after power-up.

Verification
REQ-027 Single fetch: fetch_start=1, address 16'd32, bytes 16'd64, 1-cycle backend returning mem_q=X → mem_start cycle 1 with mem_we=0, fetch_done cycle 3, fetch_q=X, grant=01 cycles 1-3.
REQ-028 Three simultaneous starts held: grants SHALL occur in order fetch, stk_rd, stk_wr; each start drops after its done; no requester is granted twice.
REQ-029 stk_wr address 16'd5, data D → mem_we=1, mem_address=5, mem_wdata=D, stk_wr_done once; stk_rd_q and fetch_q unchanged.
REQ-030 Backend never asserts mem_done, TIMEOUT=4 → mem_start drops after 4 low cycles; timeout_err and stk_rd_done pulse together; stk_rd_q unchanged.
REQ-031 Assert reset_n low during ISSUE → mem_start=0 and grant=00 asynchronously, no done pulse; after release, a fetch request is served normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM backend among fetch, stack-read and stack-write ports.
// Latency: start sampled -> mem_start next cycle; done pulses the cycle after mem_done is sampled.
// Backpressure: requesters hold start until done; a served flag blocks re-issue of a held request.
module ram_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         fetch_start,
    input  logic [15:0]  fetch_address,
    input  logic [15:0]  fetch_bytes,
    output logic [255:0] fetch_q,
    output logic         fetch_done,
    input  logic         stk_rd_start,
    input  logic [15:0]  stk_rd_address,
    input  logic [15:0]  stk_rd_bytes,
    output logic [255:0] stk_rd_q,
    output logic         stk_rd_done,
    input  logic         stk_wr_start,
    input  logic [15:0]  stk_wr_address,
    input  logic [15:0]  stk_wr_bytes,
    input  logic [255:0] stk_wr_data,
    output logic         stk_wr_done,
    output logic         mem_start,
    output logic         mem_we,
    output logic [15:0]  mem_address,
    output logic [15:0]  mem_bytes,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_q,
    input  logic         mem_done,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] G_NONE   = 2'd0;
    localparam logic [1:0] G_FETCH  = 2'd1;
    localparam logic [1:0] G_STK_RD = 2'd2;
    localparam logic [1:0] G_STK_WR = 2'd3;

    // Abort fires on the TIMEOUT-th consecutive cycle without mem_done.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [1:0]  last_grant;
    logic [2:0]  served;
    logic [7:0]  cycle_cnt;
    logic [2:0]  starts;
    logic [2:0]  eligible;
    logic [2:0]  owner;
    logic [1:0]  pick;
    logic [15:0] pick_address;
    logic [15:0] pick_bytes;

    assign starts = {stk_wr_start, stk_rd_start, fetch_start};
    assign owner  = {grant == G_STK_WR, grant == G_STK_RD, grant == G_FETCH};
    assign busy   = (state != IDLE);

    // Eligible requesters: start held and not already served for this hold.
    always_comb begin
        eligible = starts & ~served;
    end

    // Round-robin search beginning with the port after the last winner.
    always_comb begin
        pick = G_NONE;
        case (last_grant)
            G_FETCH: begin
                if (eligible[1])      pick = G_STK_RD;
                else if (eligible[2]) pick = G_STK_WR;
                else if (eligible[0]) pick = G_FETCH;
            end
            G_STK_RD: begin
                if (eligible[2])      pick = G_STK_WR;
                else if (eligible[0]) pick = G_FETCH;
                else if (eligible[1]) pick = G_STK_RD;
            end
            default: begin
                if (eligible[0])      pick = G_FETCH;
                else if (eligible[1]) pick = G_STK_RD;
                else if (eligible[2]) pick = G_STK_WR;
            end
        endcase
    end

    // Request fields of the winning port.
    always_comb begin
        pick_address = fetch_address;
        pick_bytes   = fetch_bytes;
        case (pick)
            G_STK_RD: begin
                pick_address = stk_rd_address;
                pick_bytes   = stk_rd_bytes;
            end
            G_STK_WR: begin
                pick_address = stk_wr_address;
                pick_bytes   = stk_wr_bytes;
            end
            default: ;
        endcase
    end

    // Arbitration FSM with all backend and requester outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_start   <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_bytes   <= '0;
            mem_wdata   <= '0;
            fetch_q     <= '0;
            stk_rd_q    <= '0;
            fetch_done  <= 1'b0;
            stk_rd_done <= 1'b0;
            stk_wr_done <= 1'b0;
            timeout_err <= 1'b0;
            grant       <= G_NONE;
            last_grant  <= G_STK_WR;
            served      <= '0;
            cycle_cnt   <= '0;
        end else begin
            fetch_done  <= 1'b0;
            stk_rd_done <= 1'b0;
            stk_wr_done <= 1'b0;
            timeout_err <= 1'b0;
            // A dropped start re-arms its port.
            served      <= served & starts;

            case (state)
                IDLE: begin
                    if (pick != G_NONE) begin
                        grant       <= pick;
                        last_grant  <= pick;
                        mem_start   <= 1'b1;
                        mem_we      <= (pick == G_STK_WR);
                        mem_address <= pick_address;
                        mem_bytes   <= pick_bytes;
                        if (pick == G_STK_WR) begin
                            mem_wdata <= stk_wr_data;
                        end
                        cycle_cnt   <= '0;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (mem_done) begin
                        mem_start <= 1'b0;
                        if (grant == G_FETCH) begin
                            fetch_q <= mem_q;
                        end
                        if (grant == G_STK_RD) begin
                            stk_rd_q <= mem_q;
                        end
                        {stk_wr_done, stk_rd_done, fetch_done} <= owner;
                        served    <= (served | owner) & starts;
                        state     <= RELEASE;
                    end else if (cycle_cnt == TIMEOUT_LAST) begin
                        mem_start   <= 1'b0;
                        timeout_err <= 1'b1;
                        {stk_wr_done, stk_rd_done, fetch_done} <= owner;
                        state       <= RELEASE;
                    end else begin
                        cycle_cnt <= cycle_cnt + 8'd1;
                    end
                end

                RELEASE: begin
                    if (!mem_done) begin
                        grant <= G_NONE;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
